// File: rtl/cnn_pkg.sv
// cnn_pkg: constants and helpers shared by the convolution datapath.
//   DW       - default pixel width in bits (signed pixels)
//   K        - kernel side length (3x3 window)
//   WIN_TAPS - number of taps in one window
//   win_idx  - flat tap index of window row rr (0 = top/oldest row) and
//              column cc (0 = left/oldest column); the MAC array uses the
//              same mapping to line up its weights with the window taps.
package cnn_pkg;

    localparam int DW       = 8;
    localparam int K        = 3;
    localparam int WIN_TAPS = K * K;

    function automatic int win_idx(input int rr, input int cc);
        return K * rr + cc;
    endfunction

endpackage

// File: rtl/pix_coord_cnt.sv
// pix_coord_cnt: column/row coordinate of the pixel on the current beat.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start_i     - frame restart; with valid_i the beat itself is pixel (0,0)
//   valid_i     - input beat strobe
//   col_o/row_o - coordinate of the pixel presented on this cycle's beat
//   last_col_o  - col_o is the last column of a row
//   last_pix_o  - (col_o,row_o) is the last pixel of the frame
module pix_coord_cnt #(
    parameter  int IMG_W = 109,
    parameter  int IMG_H = 109,
    localparam int CW    = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          valid_i,
    output logic [CW-1:0] col_o,
    output logic [CW-1:0] row_o,
    output logic          last_col_o,
    output logic          last_pix_o
);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;

    assign col_o      = col_q;
    assign row_o      = row_q;
    assign last_col_o = (col_q == CW'(IMG_W - 1));
    assign last_pix_o = last_col_o && (row_q == CW'(IMG_H - 1));

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_i) begin
            // A restart beat occupies (0,0), so the next beat is column 1.
            col_d = valid_i ? CW'(1) : '0;
            row_d = '0;
        end else if (valid_i) begin
            if (last_col_o) begin
                col_d = '0;
                row_d = last_pix_o ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/conv_window_3x3.sv
// conv_window_3x3: sliding 3x3 window generator behind the line-delay FIFOs.
//   clk, rst_n   - clock, asynchronous active-low reset
//   start_i      - synchronous frame restart
//   valid_i      - input beat strobe (no backpressure)
//   data_i       - current pixel, row r
//   row1_i       - line-delay tap, row r-1 (same column)
//   row2_i       - line-delay tap, row r-2 (same column)
//   win_o        - window, tap k = 3*rr+cc at [DW*k +: DW]; k=4 is the centre
//   valid_o      - one-cycle pulse: win_o holds a complete in-image window
//   row_end_o    - with valid_o: last window of the row
//   frame_done_o - with valid_o: last window of the frame
module conv_window_3x3 #(
    parameter int DW    = cnn_pkg::DW,
    parameter int IMG_W = 109,
    parameter int IMG_H = 109
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic                             valid_i,
    input  logic signed [DW-1:0]             data_i,
    input  logic signed [DW-1:0]             row1_i,
    input  logic signed [DW-1:0]             row2_i,
    output logic [cnn_pkg::WIN_TAPS*DW-1:0]  win_o,
    output logic                             valid_o,
    output logic                             row_end_o,
    output logic                             frame_done_o
);

    localparam int CW = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H);
    localparam int WB = cnn_pkg::WIN_TAPS * DW;

    logic [CW-1:0] col, row;
    logic          last_col, last_pix;
    logic          win_ok;

    logic [WB-1:0] win_q, win_d;          // shifting window registers
    logic [WB-1:0] win_out_q, win_out_d;  // last emitted window
    logic          valid_q, valid_d;
    logic          row_end_q, row_end_d;
    logic          frame_done_q, frame_done_d;

    pix_coord_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_coord (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .valid_i    (valid_i),
        .col_o      (col),
        .row_o      (row),
        .last_col_o (last_col),
        .last_pix_o (last_pix)
    );

    // A restart beat is pixel (0,0) whatever the counters hold, so it can
    // never complete a window. Stale columns left over from the previous row
    // are masked by the col >= 2 condition.
    assign win_ok = valid_i && !start_i && (col >= CW'(2)) && (row >= CW'(2));

    always_comb begin
        win_d = win_q;
        if (valid_i) begin
            for (int rr = 0; rr < cnn_pkg::K; rr++) begin
                win_d[DW*cnn_pkg::win_idx(rr, 0) +: DW] = win_q[DW*cnn_pkg::win_idx(rr, 1) +: DW];
                win_d[DW*cnn_pkg::win_idx(rr, 1) +: DW] = win_q[DW*cnn_pkg::win_idx(rr, 2) +: DW];
            end
            win_d[DW*cnn_pkg::win_idx(0, 2) +: DW] = row2_i;
            win_d[DW*cnn_pkg::win_idx(1, 2) +: DW] = row1_i;
            win_d[DW*cnn_pkg::win_idx(2, 2) +: DW] = data_i;
        end

        // The output window only moves on a qualifying beat so that win_o
        // holds steady between pulses; a bare restart clears it.
        win_out_d = win_out_q;
        if (win_ok) begin
            win_out_d = win_d;
        end else if (start_i && !valid_i) begin
            win_out_d = '0;
        end

        valid_d      = win_ok;
        row_end_d    = win_ok && last_col;
        frame_done_d = win_ok && last_pix;
    end

    // NOTE: the window registers are a handful of flops, not a RAM, so they
    // take the async reset along with the control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q        <= '0;
            win_out_q    <= '0;
            valid_q      <= 1'b0;
            row_end_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_q        <= win_d;
            win_out_q    <= win_out_d;
            valid_q      <= valid_d;
            row_end_q    <= row_end_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_o        = win_out_q;
    assign valid_o      = valid_q;
    assign row_end_o    = row_end_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_conv_window_3x3.sv
// tb_conv_window_3x3: table-driven bench for conv_window_3x3 on a 5x4 image.
module tb_conv_window_3x3;

    localparam int DW    = 8;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int NB    = IMG_W * IMG_H;
    localparam int WB    = 9 * DW;

    localparam logic [WB-1:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [WB-1:0] NEG_WIN   = 72'h80_80_80_FF_FF_FF_7F_7F_7F;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start_i;
    logic                 valid_i;
    logic signed [DW-1:0] data_i, row1_i, row2_i;
    logic [WB-1:0]        win_o;
    logic                 valid_o, row_end_o, frame_done_o;

    conv_window_3x3 #(
        .DW    (DW),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .row1_i       (row1_i),
        .row2_i       (row2_i),
        .win_o        (win_o),
        .valid_o      (valid_o),
        .row_end_o    (row_end_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d, r1, r2;
        logic          e_valid, e_row_end, e_done;
        logic [WB-1:0] e_win;
    } vec_t;

    vec_t          tbl [NB];
    int            errors = 0;
    int            checks = 0;
    int            pulses, dones;
    logic [WB-1:0] exp_hold;

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'(r * 16 + c);
    endfunction

    task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One beat of table entry i, then compare outputs one cycle later.
    task automatic apply(input int i, input logic s, input string tag);
        start_i = s;
        valid_i = 1'b1;
        data_i  = tbl[i].d;
        row1_i  = tbl[i].r1;
        row2_i  = tbl[i].r2;
        @(negedge clk);
        start_i = 1'b0;
        valid_i = 1'b0;
        if (tbl[i].e_valid) exp_hold = tbl[i].e_win;
        check($sformatf("%s[%0d] flags", tag, i), WB'({valid_o, row_end_o, frame_done_o}),
              WB'({tbl[i].e_valid, tbl[i].e_row_end, tbl[i].e_done}));
        check($sformatf("%s[%0d] win", tag, i), win_o, exp_hold);
        if (valid_o) pulses++;
        if (frame_done_o) dones++;
    endtask

    task automatic idle(input string tag);
        start_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        check({tag, " idle flags"}, WB'({valid_o, row_end_o, frame_done_o}), '0);
        check({tag, " idle win"}, win_o, exp_hold);
    endtask

    task automatic run_frame(input string tag);
        for (int i = 0; i < NB; i++) apply(i, 1'b0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        // Expected table: window taps derived from pixel coordinates.
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                int i;
                i = r * IMG_W + c;
                tbl[i].d         = pix(r, c);
                tbl[i].r1        = pix(r - 1, c);
                tbl[i].r2        = pix(r - 2, c);
                tbl[i].e_valid   = (r >= 2) && (c >= 2);
                tbl[i].e_row_end = tbl[i].e_valid && (c == IMG_W - 1);
                tbl[i].e_done    = tbl[i].e_row_end && (r == IMG_H - 1);
                tbl[i].e_win     = '0;
                if (tbl[i].e_valid) begin
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++)
                            tbl[i].e_win[DW*(3*rr+cc) +: DW] = pix(r - 2 + rr, c - 2 + cc);
                end
            end
        end

        rst_n   = 1'b0;
        start_i = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        row1_i  = '0;
        row2_i  = '0;
        repeat (2) @(negedge clk);
        check("reset flags", WB'({valid_o, row_end_o, frame_done_o}), '0);
        check("reset win", win_o, '0);
        rst_n    = 1'b1;
        exp_hold = '0;

        // Continuous frame; first window checked against a literal too.
        pulses = 0; dones = 0;
        for (int i = 0; i < NB; i++) begin
            apply(i, 1'b0, "cont");
            if (i == 2 * IMG_W + 2) check("cont first window", win_o, FIRST_WIN);
        end
        check("cont pulses", WB'(pulses), WB'(6));
        check("cont frame_done count", WB'(dones), WB'(1));

        // Beats separated by idle cycles.
        pulses = 0; dones = 0;
        for (int i = 0; i < NB; i++) begin
            apply(i, 1'b0, "gap");
            idle("gap");
        end
        check("gap pulses", WB'(pulses), WB'(6));

        // Two back-to-back frames: counters must wrap from (4,3) to (0,0).
        pulses = 0; dones = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NB; i++) begin
                apply(i, 1'b0, "b2b");
                if (f == 1 && i == 2 * IMG_W + 2) check("b2b frame2 first window", win_o, FIRST_WIN);
            end
        end
        check("b2b pulses", WB'(pulses), WB'(12));
        check("b2b frame_done count", WB'(dones), WB'(2));

        // Negative / extreme pixels pass bit-exact.
        for (int i = 0; i < NB; i++) begin
            valid_i = 1'b1;
            data_i  = -8'sd128;
            row1_i  = -8'sd1;
            row2_i  = 8'sd127;
            @(negedge clk);
            valid_i = 1'b0;
            if (i == 2 * IMG_W + 2) begin
                check("neg window", win_o, NEG_WIN);
                check("neg tap k8", WB'(win_o[DW*8 +: DW]), WB'(8'h80));
                check("neg tap k0", WB'(win_o[0 +: DW]), WB'(8'h7F));
            end
        end
        exp_hold = NEG_WIN;

        // Restart with a beat at frame beat 9: aborted frame never completes.
        pulses = 0; dones = 0;
        for (int i = 0; i < 9; i++) apply(i, 1'b0, "abort");
        apply(0, 1'b1, "restart");
        for (int i = 1; i < NB; i++) apply(i, 1'b0, "restart");
        check("restart pulses", WB'(pulses), WB'(6));
        check("restart frame_done count", WB'(dones), WB'(1));

        // Restart without a beat mid-frame: outputs clear, counters to (0,0).
        for (int i = 0; i < 14; i++) apply(i, 1'b0, "pre_start");
        start_i = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        check("bare start flags", WB'({valid_o, row_end_o, frame_done_o}), '0);
        check("bare start win", win_o, '0);
        exp_hold = '0;
        pulses = 0; dones = 0;
        run_frame("after_start");
        check("after_start pulses", WB'(pulses), WB'(6));
        check("after_start frame_done count", WB'(dones), WB'(1));

        // Asynchronous reset mid-frame after the second window.
        pulses = 0;
        for (int i = 0; i < 14; i++) apply(i, 1'b0, "pre_rst");
        check("pre_rst pulses", WB'(pulses), WB'(2));
        #2 rst_n = 1'b0;
        #1;
        check("async rst flags", WB'({valid_o, row_end_o, frame_done_o}), '0);
        check("async rst win", win_o, '0);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_hold = '0;
        pulses = 0; dones = 0;
        run_frame("after_rst");
        check("after_rst pulses", WB'(pulses), WB'(6));
        check("after_rst frame_done count", WB'(dones), WB'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_3x3.md
Name: conv_window_3x3

Overview:
Sliding 3x3 window generator. It sits directly downstream of the two cascaded line-delay FIFOs in the convolution datapath of the VGG accelerator. Each valid beat, it takes the current pixel plus the two line-delayed taps and shifts them into a 3x3 register window. It emits the window only when all nine taps lie inside the image (stride 1, no padding) and flags row and frame boundaries for the downstream MAC array.

Parameters:
DW, 8, signed pixel width in bits
IMG_W, 109, image width in pixels; equals line-delay depth
IMG_H, 109, image height in pixels
CW, $clog2(IMG_W > IMG_H ? IMG_W : IMG_H), counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  synchronous frame restart; counters to 0
valid_i  in  1  input beat strobe; no backpressure
data_i  in  DW  signed current pixel, row r
row1_i  in  DW  signed line-delay tap, row r-1, same beat as data_i
row2_i  in  DW  signed line-delay tap, row r-2, same beat as data_i
win_o  out  9*DW  window; tap k=3*rr+cc at [DW*k +: DW]; rr=0 top (oldest row), cc=0 left (oldest column); k=4 is centre
valid_o  out  1  win_o holds a complete in-image window
row_end_o  out  1  with valid_o: last window of the current row
frame_done_o  out  1  with valid_o: last window of the frame

Behaviour:
- Reset (async, rst_n=0): win_o=0, valid_o=0, row_end_o=0, frame_done_o=0, col_cnt=0, row_cnt=0, window regs=0.
- Beat = cycle with valid_i=1. Idle cycles hold window regs and counters. All outputs are registered.
- On a beat, shift the window regs left by one column: cc0<=cc1, cc1<=cc2. The new cc2 column is {top=row2_i, mid=row1_i, bottom=data_i}.
- col_cnt/row_cnt give the coordinate of the pixel on the current beat. col_cnt increments on each beat. At IMG_W-1, col_cnt wraps to 0 and row_cnt increments. At (IMG_W-1, IMG_H-1), both wrap to 0.
- Window validity on a beat: row_cnt>=2 and col_cnt>=2.
- Latency is 1 cycle. valid_o rises on the cycle after a qualifying beat, and win_o shows the window including that beat's column.
- valid_o is a one-cycle pulse per qualifying beat. On cycles after a non-qualifying beat or an idle cycle, valid_o=0 and win_o holds its last value.
- row_end_o = valid_o and that beat's col_cnt==IMG_W-1.
- frame_done_o = valid_o and that beat's coordinate is (IMG_W-1, IMG_H-1).
- No clearing at row starts. Stale columns from the previous row are masked by the col_cnt>=2 rule.
- Windows per frame: (IMG_W-2)*(IMG_H-2). Windows per row: IMG_W-2.
- start_i=1 without valid_i: counters go to 0 and window regs are untouched. Outputs go to 0 on the next cycle.
- start_i=1 with valid_i: the beat is treated as pixel (0,0). Afterwards col_cnt=1, row_cnt=0, and the column is shifted in.
- start_i mid-frame abandons the partial frame. No frame_done_o is emitted for it.
- Reset mid-frame behaves exactly like power-on. The next beat is pixel (0,0).
- There is no arithmetic on pixel values. Taps pass bit-exact, signed, DW wide.
- The sign attribute of valid_i is irrelevant; treat it as a plain 1-bit strobe.

Decomposition:
- Shared package cnn_pkg holds:
  - DW and K=3;
  - localparam WIN_TAPS=9;
  - a function win_idx(rr,cc)=3*rr+cc, reused by the MAC array for weight alignment.
- Coordinate counters form one natural sub-module: pix_coord_cnt. It has params IMG_W, IMG_H and ports clk, rst_n, start_i, valid_i, col_o, row_o, last_col_o, last_pix_o.
- The window shift regs and output registering stay in the top module.

Test Plan:
- IMG_W=5, IMG_H=4; data_i=row*16+col, row1_i=(row-1)*16+col, row2_i=(row-2)*16+col, with one beat per cycle -> exactly 6 valid_o pulses. The first pulse appears 1 cycle after beat (2,2) with win_o taps k0..k8 = 0x00,01,02,10,11,12,20,21,22. row_end_o on pulses 3 and 6. frame_done_o only on pulse 6.
- Same frame with valid_i toggled 1-0-1-0 -> identical 6 windows in order. valid_o never high on the cycle following an idle cycle.
- Two back-to-back frames -> 12 pulses. The first window of frame 2 equals frame 1's first window, proving counter wrap at (4,3) to (0,0).
- Negative pixels (data_i=-128, row1_i=-1, row2_i=127) -> taps pass unmodified; win_o[DW*8 +: DW]=0x80 and win_o[0 +: DW]=0x7F.
- start_i pulsed with valid_i at frame beat 9 (mid row 1) -> no frame_done_o for the aborted frame. Exactly 6 windows follow, counted from the restart beat as (0,0).
- Assert rst_n=0 asynchronously mid-frame after window 2 -> all outputs 0 immediately. After release, a full frame yields 6 windows starting from (0,0).
